pc060ha_master_sequencer: RTL

Synchronous master-side controller for the PC060HA sound-communication chip. It turns host byte commands into PC060HA page and nibble bus cycles, polls the status page, and retrieves slave reply bytes. It also sequences slave reset writes. It sits between the main-CPU glue logic and the nMCS/nMRD/nMWR/MA0/MD pins of the chip, and is the only master the chip has.

---
 rtl/pc060ha_master_sequencer.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pc060ha_master_sequencer.sv
`timescale 1ns/1ps
// pc060ha_master_sequencer
//
// Master-side controller for the PC060HA sound-communication chip. Host
// command bytes become page-select and nibble write cycles. The status page
// is polled at a fixed idle interval, and slave reply bytes are read back as
// two nibbles. Slave reset writes, which assert or release the slave, are
// also sequenced here.
//
// Parameters
//   STROBE_CYCLES  width of each nMRD/nMWR low pulse in clk cycles (>= 1)
//   POLL_INTERVAL  idle clk cycles between status polls (>= 1)
//
// Ports
//   clk, reset_request     clock; asynchronous active-high reset
//   cmd_valid/cmd_data     host command byte offer
//   cmd_ready              one-entry command holding register is empty
//   rsp_valid/rsp_data     reply byte held for the host
//   rsp_ready              host consumes the reply
//   srst_req/srst_assert   one-cycle slave-reset request and its level
//   nMCS, nMRD, nMWR       chip strobes, active-low
//   MA0                    0 = page-register write, 1 = data access
//   MD_o/MD_oe/MD_i        nibble data bus (write data, drive enable, read data)
//   busy                   a bus sequence is in progress
module pc060ha_master_sequencer #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned POLL_INTERVAL = 16
) (
    input  logic       clk,
    input  logic       reset_request,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    input  logic       srst_req,
    input  logic       srst_assert,
    output logic       nMCS,
    output logic       nMRD,
    output logic       nMWR,
    output logic       MA0,
    output logic [3:0] MD_o,
    output logic       MD_oe,
    input  logic [3:0] MD_i,
    output logic       busy
);

    // One bus access: SETUP, STROBE x STROBE_CYCLES, HOLD, GAP.
    localparam int unsigned ACCESS_CYCLES = STROBE_CYCLES + 3;
    localparam int unsigned PH_W = $clog2(ACCESS_CYCLES);
    localparam logic [PH_W-1:0] PH_STB_LAST = PH_W'(STROBE_CYCLES);
    localparam logic [PH_W-1:0] PH_HOLD     = PH_W'(STROBE_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LAST     = PH_W'(STROBE_CYCLES + 2);

    localparam int unsigned PC_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(POLL_INTERVAL - 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] POLL_SEL = 4'd1;
    localparam logic [3:0] POLL_RD  = 4'd2;
    localparam logic [3:0] DECIDE   = 4'd3;
    localparam logic [3:0] TX_SEL0  = 4'd4;
    localparam logic [3:0] TX_WR0   = 4'd5;
    localparam logic [3:0] TX_SEL1  = 4'd6;
    localparam logic [3:0] TX_WR1   = 4'd7;
    localparam logic [3:0] RX_SEL0  = 4'd8;
    localparam logic [3:0] RX_RD0   = 4'd9;
    localparam logic [3:0] RX_SEL1  = 4'd10;
    localparam logic [3:0] RX_RD1   = 4'd11;
    localparam logic [3:0] RST_SEL  = 4'd12;
    localparam logic [3:0] RST_WR   = 4'd13;

    logic [3:0]      state;
    logic [3:0]      state_next;
    logic [PH_W-1:0] phase;
    logic [PC_W-1:0] poll_cnt;

    logic            cmd_full;
    logic [7:0]      cmd_buf;
    logic            srst_pend;
    logic            srst_val;
    logic            rst_data;
    logic            hold;
    logic            stat_shf;   // slave_half_full from the last poll
    logic            stat_mhf;   // master_half_full from the last poll
    logic [3:0]      rx_lo;
    logic [3:0]      rx_hi;

    logic            acc_done;
    logic            sample;
    logic            strobe;
    logic            is_write;
    logic            is_data;
    logic [3:0]      wdata;

    assign acc_done  = (phase == PH_LAST);
    assign sample    = (phase == PH_STB_LAST);
    assign strobe    = (phase != '0) && (phase <= PH_STB_LAST);
    assign cmd_ready = ~cmd_full;
    assign busy      = (state != IDLE);

    // Next-state decision
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (srst_pend)
                    state_next = RST_SEL;
                else if (!hold && poll_cnt == PC_LAST)
                    state_next = POLL_SEL;
            end
            POLL_SEL: if (acc_done) state_next = POLL_RD;
            // The read access ends after HOLD; DECIDE doubles as its GAP cycle
            // so the poll still spans exactly two accesses.
            POLL_RD:  if (phase == PH_HOLD) state_next = DECIDE;
            DECIDE: begin
                if (srst_pend)
                    state_next = RST_SEL;
                else if (stat_shf && !rsp_valid)
                    state_next = RX_SEL0;
                else if (cmd_full && !stat_mhf)
                    state_next = TX_SEL0;
                else
                    state_next = IDLE;
            end
            TX_SEL0:  if (acc_done) state_next = TX_WR0;
            TX_WR0:   if (acc_done) state_next = TX_SEL1;
            TX_SEL1:  if (acc_done) state_next = TX_WR1;
            TX_WR1:   if (acc_done) state_next = IDLE;
            RX_SEL0:  if (acc_done) state_next = RX_RD0;
            RX_RD0:   if (acc_done) state_next = RX_SEL1;
            RX_SEL1:  if (acc_done) state_next = RX_RD1;
            RX_RD1:   if (acc_done) state_next = IDLE;
            RST_SEL:  if (acc_done) state_next = RST_WR;
            RST_WR:   if (acc_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Per-state access attributes
    always_comb begin
        is_write = 1'b0;
        is_data  = 1'b0;
        wdata    = '0;
        case (state)
            POLL_SEL, RST_SEL: begin is_write = 1'b1; wdata = 4'b0100; end
            TX_SEL0,  RX_SEL0: begin is_write = 1'b1; wdata = 4'b0000; end
            TX_SEL1,  RX_SEL1: begin is_write = 1'b1; wdata = 4'b0001; end
            TX_WR0: begin is_write = 1'b1; is_data = 1'b1; wdata = cmd_buf[3:0]; end
            TX_WR1: begin is_write = 1'b1; is_data = 1'b1; wdata = cmd_buf[7:4]; end
            RST_WR: begin is_write = 1'b1; is_data = 1'b1; wdata = {3'b000, rst_data}; end
            POLL_RD, RX_RD0, RX_RD1, DECIDE: is_data = 1'b1;
            default: ;
        endcase
    end

    // Bus pins decoded from state and phase, so an asynchronous reset of the
    // state register releases every strobe immediately.
    always_comb begin
        nMCS  = 1'b1;
        nMRD  = 1'b1;
        nMWR  = 1'b1;
        MA0   = 1'b0;
        MD_o  = '0;
        MD_oe = 1'b0;
        if (state != IDLE) begin
            MA0  = is_data;
            MD_o = wdata;
            if (state != DECIDE) begin
                nMCS = ~(phase <= PH_HOLD);
                if (is_write) begin
                    MD_oe = (phase <= PH_HOLD);
                    nMWR  = ~strobe;
                end else begin
                    nMRD  = ~strobe;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset_request) begin
        if (reset_request) begin
            state     <= IDLE;
            phase     <= '0;
            poll_cnt  <= '0;
            cmd_full  <= 1'b0;
            cmd_buf   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            srst_pend <= 1'b0;
            srst_val  <= 1'b0;
            rst_data  <= 1'b0;
            hold      <= 1'b0;
            stat_shf  <= 1'b0;
            stat_mhf  <= 1'b0;
            rx_lo     <= '0;
            rx_hi     <= '0;
        end else begin
            state <= state_next;

            if (state_next != state || state == IDLE)
                phase <= '0;
            else
                phase <= phase + 1'b1;

            if (state == IDLE && state_next == IDLE && !hold)
                poll_cnt <= poll_cnt + 1'b1;
            else
                poll_cnt <= '0;

            if (state == POLL_RD && sample) begin
                stat_shf <= MD_i[2];
                stat_mhf <= MD_i[0];
            end
            if (state == RX_RD0 && sample)
                rx_lo <= MD_i;
            if (state == RX_RD1 && sample)
                rx_hi <= MD_i;

            // Command holding register; TX cannot run while it is empty.
            if (state == TX_WR1 && acc_done)
                cmd_full <= 1'b0;
            else if (cmd_valid && !cmd_full) begin
                cmd_full <= 1'b1;
                cmd_buf  <= cmd_data;
            end

            // Reply holding register; RX only starts while it is empty.
            if (state == RX_RD1 && acc_done) begin
                rsp_valid <= 1'b1;
                rsp_data  <= {rx_hi, rx_lo};
            end else if (rsp_valid && rsp_ready)
                rsp_valid <= 1'b0;

            // The level being written is frozen on entry to RST_SEL. A request
            // arriving mid-sequence with a different level keeps the pending
            // flag set so that level is written next; a same-level repeat is
            // already satisfied by the write in flight.
            if (state_next == RST_SEL && state != RST_SEL)
                rst_data <= srst_val;
            if (srst_req) begin
                srst_pend <= 1'b1;
                srst_val  <= srst_assert;
            end else if (state == RST_WR && acc_done && srst_val == rst_data)
                srst_pend <= 1'b0;
            if (state == RST_WR && acc_done)
                hold <= rst_data;
        end
    end

endmodule
